// File: rtl/pu_feeder.sv
// Front end of the 4-lane PU: holds the weight set and packs serial activations into groups of four.
// Each group is presented for one cycle, and its result is marked PU_LAT cycles later.
module pu_feeder #(
  parameter int DATA_W = 5,
  parameter int PU_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_load,
  input  logic [4*DATA_W-1:0] w_in,
  input  logic                a_valid,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_last,
  output logic                a_ready,
  output logic [DATA_W-1:0]   a1,
  output logic [DATA_W-1:0]   a2,
  output logic [DATA_W-1:0]   a3,
  output logic [DATA_W-1:0]   a4,
  output logic [DATA_W-1:0]   w1,
  output logic [DATA_W-1:0]   w2,
  output logic [DATA_W-1:0]   w3,
  output logic [DATA_W-1:0]   w4,
  output logic                issue,
  output logic                res_valid,
  output logic [7:0]          grp_cnt
);

  typedef enum logic {FILL, ISSUE} state_t;

  state_t            state_reg;
  logic              wts_ok_reg;
  logic [1:0]        cnt_reg;
  logic              issue_reg;
  logic [7:0]        grp_cnt_reg;
  logic [PU_LAT-1:0] lat_reg;
  logic [PU_LAT-1:0] lat_next;

  logic [DATA_W-1:0] slot_reg   [4];
  logic [DATA_W-1:0] slot_next  [4];
  logic [DATA_W-1:0] wt_reg     [4];
  logic [DATA_W-1:0] wt_next    [4];
  logic [DATA_W-1:0] a_lane_reg [4];
  logic [DATA_W-1:0] w_lane_reg [4];

  logic beat_ok;
  logic w_take;
  logic grp_done;

  assign beat_ok  = (state_reg == FILL) && wts_ok_reg && a_valid;
  assign w_take   = (state_reg == FILL) && (cnt_reg == 2'd0) && w_load;
  assign grp_done = beat_ok && ((cnt_reg == 2'd3) || a_last);

  // The next-state views include this cycle's beat and weight load.
  // A group that closes in the same cycle therefore issues with them.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign slot_next[gi] = (beat_ok && (cnt_reg == 2'(gi))) ? a_data : slot_reg[gi];
      assign wt_next[gi]   = w_take ? w_in[gi*DATA_W +: DATA_W] : wt_reg[gi];
    end
  endgenerate

  assign lat_next[0] = issue_reg;
  generate
    for (gi = 1; gi < PU_LAT; gi++) begin : g_lat
      assign lat_next[gi] = lat_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FILL;
      wts_ok_reg  <= 1'b0;
      cnt_reg     <= 2'd0;
      issue_reg   <= 1'b0;
      grp_cnt_reg <= 8'd0;
      lat_reg     <= '0;
      for (int i = 0; i < 4; i++) begin
        slot_reg[i]   <= '0;
        wt_reg[i]     <= '0;
        a_lane_reg[i] <= '0;
        w_lane_reg[i] <= '0;
      end
    end else begin
      issue_reg <= 1'b0;
      lat_reg   <= lat_next;
      for (int i = 0; i < 4; i++) begin
        wt_reg[i] <= wt_next[i];
      end
      case (state_reg)
        FILL: begin
          if (w_take) begin
            wts_ok_reg <= 1'b1;
          end
          if (beat_ok) begin
            cnt_reg <= cnt_reg + 2'd1;
          end
          for (int i = 0; i < 4; i++) begin
            slot_reg[i] <= slot_next[i];
          end
          if (grp_done) begin
            for (int i = 0; i < 4; i++) begin
              a_lane_reg[i] <= slot_next[i];
              w_lane_reg[i] <= wt_next[i];
            end
            issue_reg   <= 1'b1;
            grp_cnt_reg <= grp_cnt_reg + 8'd1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg <= 2'd0;
          for (int i = 0; i < 4; i++) begin
            slot_reg[i] <= '0;
          end
          state_reg <= FILL;
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign a_ready   = (state_reg == FILL) && wts_ok_reg;
  assign issue     = issue_reg;
  assign res_valid = lat_reg[PU_LAT-1];
  assign grp_cnt   = grp_cnt_reg;
  assign a1 = a_lane_reg[0];
  assign a2 = a_lane_reg[1];
  assign a3 = a_lane_reg[2];
  assign a4 = a_lane_reg[3];
  assign w1 = w_lane_reg[0];
  assign w2 = w_lane_reg[1];
  assign w3 = w_lane_reg[2];
  assign w4 = w_lane_reg[3];

endmodule
